// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks the pc through a one-outstanding instruction bus
//   and presents each fetched word to IF/ID. Latency: at least 3 cycles per instruction
//   (REQ, WAIT, VALID); the data-return cycle stretches WAIT. Backpressure: stop[0] holds VALID.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stop[5:0]         stall vector; bit 0 freezes fetch (bit 1 belongs to IF/ID, unused here)
//   branch_flag/_target  taken-branch pulse from ID plus its target
//   flush/new_pc      exception/eret redirect pulse plus its target (wins over branches)
//   inst_req/addr     request strobe and address toward the instruction bus
//   inst_addr_ok      request accepted; inst_data_ok/inst_rdata return the word
//   if_pc/if_inst     fetched pc/instruction, zero (bubble) outside VALID
//   stallreq_if       asks the stall controller to hold while no instruction is ready
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stop,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  state_t      state;
  logic [31:0] pc;
  logic        cancel;   // the outstanding bus response belongs to a flushed fetch
  logic        br_pend;  // branch seen before its delay slot reached VALID
  logic [31:0] br_tgt;

  // Only stop[0] concerns fetch; the IF/ID freeze bit is consumed downstream.
  logic unused_stop;
  assign unused_stop = ^stop[5:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      cancel  <= 1'b0;
      br_pend <= 1'b0;
      br_tgt  <= 32'h0;
      if_pc   <= 32'h0;
      if_inst <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (flush) begin
            pc      <= new_pc;
            br_pend <= 1'b0;
          end else if (branch_flag) begin
            br_pend <= 1'b1;
            br_tgt  <= branch_target;
          end
        end

        REQ: begin
          if (flush) begin
            pc      <= new_pc;
            br_pend <= 1'b0;
            // The old address was already accepted: its data must be dropped.
            if (inst_addr_ok) begin
              state  <= WAIT;
              cancel <= 1'b1;
            end
          end else begin
            if (branch_flag) begin
              br_pend <= 1'b1;
              br_tgt  <= branch_target;
            end
            if (inst_addr_ok) state <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            pc      <= new_pc;
            br_pend <= 1'b0;
            if (inst_data_ok) begin
              cancel <= 1'b0;
              state  <= REQ;
            end else begin
              cancel <= 1'b1;
            end
          end else begin
            if (branch_flag) begin
              br_pend <= 1'b1;
              br_tgt  <= branch_target;
            end
            if (inst_data_ok) begin
              if (cancel) begin
                cancel <= 1'b0;
                state  <= REQ;
              end else begin
                if_pc   <= pc;
                if_inst <= inst_rdata;
                state   <= VALID;
              end
            end
          end
        end

        VALID: begin
          if (flush) begin
            pc      <= new_pc;
            br_pend <= 1'b0;
            if_pc   <= 32'h0;
            if_inst <= 32'h0;
            state   <= REQ;
          end else if (stop[0]) begin
            // Held: a branch resolved meanwhile is parked so the pulse is not lost.
            if (branch_flag) begin
              br_pend <= 1'b1;
              br_tgt  <= branch_target;
            end
          end else begin
            // The word leaving VALID is the delay slot of any branch seen so far.
            if (br_pend) begin
              pc      <= br_tgt;
              br_pend <= 1'b0;
            end else if (branch_flag) begin
              pc <= branch_target;
            end else begin
              pc <= pc + 32'd4;
            end
            if_pc   <= 32'h0;
            if_inst <= 32'h0;
            state   <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; if_pc/if_inst are cleared on every exit from VALID.
  assign inst_req    = (state == REQ);
  assign inst_addr   = pc;
  assign stallreq_if = (state != VALID);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stop;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stop         (stop),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .stallreq_if  (stallreq_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  logic [31:0] q_addr[$];
  out_t        q_out[$];

  // Bus model state: response countdown after an accepted request.
  int          lat = 1;
  int          bus_cnt = 0;
  logic [31:0] bus_addr = 32'h0;
  logic        prev_stall = 1'b1;

  typedef struct {
    logic        stop0;
    logic        bf;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] npc;
    logic        req;
    logic        stl;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] iinst;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mkv(input logic s, input logic bf, input logic [31:0] bt,
                               input logic fl, input logic [31:0] npc, input logic req,
                               input logic stl, input logic [31:0] addr,
                               input logic [31:0] ipc, input logic [31:0] iinst);
    vec_t v;
    v.stop0 = s;  v.bf = bf;   v.bt = bt;     v.fl = fl;   v.npc = npc;
    v.req = req;  v.stl = stl; v.addr = addr; v.ipc = ipc; v.iinst = iinst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    out_t o;
    o.pc   = a;
    o.inst = img(a);
    q_out.push_back(o);
  endtask

  // Ends the current cycle: scores any handshake, advances the bus model across
  // the clock edge, scores a fresh VALID entry, and clears the one-cycle pulses.
  task automatic cyc();
    out_t o;
    if (inst_req === 1'b1 && inst_addr_ok === 1'b1) begin
      if (q_addr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_addr: unexpected request to %h", inst_addr);
      end else begin
        chk("sb_addr", inst_addr, q_addr.pop_front());
      end
      bus_cnt  = lat;
      bus_addr = inst_addr;
    end
    @(posedge clk);
    #1;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hDEAD_BEEF;
    if (bus_cnt > 0) begin
      bus_cnt--;
      if (bus_cnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = img(bus_addr);
      end
    end
    if (stallreq_if === 1'b0 && prev_stall === 1'b1) begin
      if (q_out.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_out: unexpected instruction pc %h", if_pc);
      end else begin
        o = q_out.pop_front();
        chk("sb_out_pc", if_pc, o.pc);
        chk("sb_out_inst", if_inst, o.inst);
      end
    end
    prev_stall  = stallreq_if;
    flush       = 1'b0;
    branch_flag = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stop = 6'h0; branch_flag = 1'b0; branch_target = 32'h0;
    flush = 1'b0; new_pc = 32'h0;
    inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'hDEAD_BEEF;

    // Cycle-by-cycle vectors from reset release: {stop0,bf,bt,fl,npc} -> {req,stall,addr,if_pc,if_inst}
    tbl[0]  = mkv(0, 0, 0, 0, 0,             0, 1, 32'hBFC00000, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0, 0,             1, 1, 32'hBFC00000, 0, 0);
    tbl[2]  = mkv(0, 0, 0, 0, 0,             0, 1, 32'hBFC00000, 0, 0);
    tbl[3]  = mkv(0, 0, 0, 0, 0,             0, 0, 32'hBFC00000, 32'hBFC00000, img(32'hBFC00000));
    tbl[4]  = mkv(0, 0, 0, 0, 0,             1, 1, 32'hBFC00004, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 0, 0,             0, 1, 32'hBFC00004, 0, 0);
    tbl[6]  = mkv(1, 0, 0, 0, 0,             0, 0, 32'hBFC00004, 32'hBFC00004, img(32'hBFC00004));
    tbl[7]  = mkv(1, 0, 0, 0, 0,             0, 0, 32'hBFC00004, 32'hBFC00004, img(32'hBFC00004));
    tbl[8]  = mkv(1, 0, 0, 0, 0,             0, 0, 32'hBFC00004, 32'hBFC00004, img(32'hBFC00004));
    tbl[9]  = mkv(0, 0, 0, 0, 0,             0, 0, 32'hBFC00004, 32'hBFC00004, img(32'hBFC00004));
    tbl[10] = mkv(0, 0, 0, 0, 0,             1, 1, 32'hBFC00008, 0, 0);
    tbl[11] = mkv(0, 0, 0, 0, 0,             0, 1, 32'hBFC00008, 0, 0);
    tbl[12] = mkv(0, 1, 32'h80001000, 0, 0,  0, 0, 32'hBFC00008, 32'hBFC00008, img(32'hBFC00008));
    tbl[13] = mkv(0, 0, 0, 0, 0,             1, 1, 32'h80001000, 0, 0);
    tbl[14] = mkv(0, 0, 0, 0, 0,             0, 1, 32'h80001000, 0, 0);
    tbl[15] = mkv(0, 0, 0, 1, 32'hBFC0000C,  0, 0, 32'h80001000, 32'h80001000, img(32'h80001000));

    cyc();
    cyc();
    chk("rst_req",   {31'h0, inst_req},    32'h0);
    chk("rst_addr",  inst_addr,            32'hBFC00000);
    chk("rst_stall", {31'h0, stallreq_if}, 32'h1);
    chk("rst_if_pc", if_pc,                32'h0);
    chk("rst_inst",  if_inst,              32'h0);
    rst = 1'b0;

    foreach (q_addr[i]) q_addr.delete(i);
    q_addr.push_back(32'hBFC00000); q_addr.push_back(32'hBFC00004);
    q_addr.push_back(32'hBFC00008); q_addr.push_back(32'h80001000);
    push_fetch(32'hBFC00000); push_fetch(32'hBFC00004);
    push_fetch(32'hBFC00008); push_fetch(32'h80001000);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_req", i),   {31'h0, inst_req},    {31'h0, tbl[i].req});
      chk($sformatf("v%0d_stall", i), {31'h0, stallreq_if}, {31'h0, tbl[i].stl});
      chk($sformatf("v%0d_addr", i),  inst_addr,            tbl[i].addr);
      chk($sformatf("v%0d_if_pc", i), if_pc,                tbl[i].ipc);
      chk($sformatf("v%0d_inst", i),  if_inst,              tbl[i].iinst);
      stop          = {5'h0, tbl[i].stop0};
      branch_flag   = tbl[i].bf;
      branch_target = tbl[i].bt;
      flush         = tbl[i].fl;
      new_pc        = tbl[i].npc;
      cyc();
    end

    // Branch while the delay slot is still in WAIT.
    q_addr.push_back(32'hBFC0000C); q_addr.push_back(32'h80002000);
    push_fetch(32'hBFC0000C); push_fetch(32'h80002000);
    chk("wslot_req",  {31'h0, inst_req}, 32'h1);
    chk("wslot_addr", inst_addr,         32'hBFC0000C);
    cyc();
    branch_flag = 1'b1; branch_target = 32'h80002000;
    cyc();
    chk("wslot_valid_pc", if_pc, 32'hBFC0000C);
    cyc();
    chk("wslot_redirect", inst_addr, 32'h80002000);
    cyc();
    cyc();
    flush = 1'b1; new_pc = 32'hBFC00010;
    cyc();

    // Flush one cycle after addr_ok, with a branch already pending.
    q_addr.push_back(32'hBFC00010); q_addr.push_back(32'hBFC00380);
    push_fetch(32'hBFC00380);
    chk("fl_req_addr", inst_addr, 32'hBFC00010);
    branch_flag = 1'b1; branch_target = 32'h80003000; lat = 2;
    cyc();
    flush = 1'b1; new_pc = 32'hBFC00380;
    cyc();
    chk("fl_discard_stall", {31'h0, stallreq_if}, 32'h1);
    chk("fl_discard_inst",  if_inst,              32'h0);
    lat = 1;
    cyc();
    chk("fl_new_req",  {31'h0, inst_req}, 32'h1);
    chk("fl_new_addr", inst_addr,         32'hBFC00380);
    chk("fl_new_inst", if_inst,           32'h0);
    cyc();
    cyc();
    cyc();
    chk("fl_br_cleared", inst_addr, 32'hBFC00384);

    // Flush in REQ without acceptance, then pc wrap at the top of the space.
    q_addr.push_back(32'hFFFFFFFC); q_addr.push_back(32'h00000000);
    q_addr.push_back(32'hBFC00100);
    push_fetch(32'hFFFFFFFC); push_fetch(32'h00000000);
    inst_addr_ok = 1'b0; flush = 1'b1; new_pc = 32'hFFFFFFFC;
    cyc();
    inst_addr_ok = 1'b1;
    chk("reqfl_req",  {31'h0, inst_req}, 32'h1);
    chk("reqfl_addr", inst_addr,         32'hFFFFFFFC);
    cyc();
    cyc();
    cyc();
    chk("wrap_addr", inst_addr, 32'h00000000);
    cyc();
    cyc();
    // Flush overrides a held VALID.
    stop = 6'h1; flush = 1'b1; new_pc = 32'hBFC00100;
    cyc();
    chk("vflush_req",   {31'h0, inst_req},    32'h1);
    chk("vflush_addr",  inst_addr,            32'hBFC00100);
    chk("vflush_stall", {31'h0, stallreq_if}, 32'h1);
    stop = 6'h0; lat = 3;
    cyc();

    // Reset while a response is outstanding; the late data_ok must be ignored.
    q_addr.push_back(32'hBFC00000);
    push_fetch(32'hBFC00000);
    rst = 1'b1; lat = 1;
    cyc();
    chk("mrst_req",   {31'h0, inst_req},    32'h0);
    chk("mrst_addr",  inst_addr,            32'hBFC00000);
    chk("mrst_stall", {31'h0, stallreq_if}, 32'h1);
    rst = 1'b0;
    cyc();
    chk("mrst_first_req", {31'h0, inst_req}, 32'h1);
    cyc();
    cyc();
    stop = 6'h1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_stall", {31'h0, stallreq_if}, 32'h0);
      chk("hold_if_pc", if_pc,                32'hBFC00000);
      cyc();
    end

    chk("sb_addr_left", q_addr.size(), 32'h0);
    chk("sb_out_left",  q_out.size(),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
